// File: rtl/twobit_btb_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry, combinational lookup and next-cycle update from execute.
module twobit_btb_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_ROWS   = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RD_f,
  input  logic [DATA_WIDTH-1:0] PC_f,
  input  logic                  update_en,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_uncond,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  mispredict,
  output logic                  predict_taken_f,
  output logic [DATA_WIDTH-1:0] branch_target_f,
  output logic [STAT_WIDTH-1:0] perf_lookups,
  output logic [STAT_WIDTH-1:0] perf_mispredicts
);

  localparam int IDX_BITS = $clog2(BTB_ROWS);
  localparam int TAG_W    = DATA_WIDTH - IDX_BITS - 2;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // No handshake: lookup is a pure function of PC_f/RD_f and the table, and an
  // update is accepted unconditionally in every cycle update_en is high.

  logic [BTB_ROWS-1:0]   r_valid;
  logic [BTB_ROWS-1:0]   r_uncond;
  logic [TAG_W-1:0]      r_tag    [BTB_ROWS];
  logic [DATA_WIDTH-1:0] r_target [BTB_ROWS];
  logic [1:0]            r_ctr    [BTB_ROWS];
  logic [STAT_WIDTH-1:0] r_perf_lookups;
  logic [STAT_WIDTH-1:0] r_perf_mispredicts;

  // ---------------- lookup ----------------
  logic [IDX_BITS-1:0] w_f_idx;
  logic [TAG_W-1:0]    w_f_tag;
  logic                w_f_qual;
  logic                w_f_hit;

  assign w_f_idx  = PC_f[IDX_BITS+1:2];
  assign w_f_tag  = PC_f[DATA_WIDTH-1:IDX_BITS+2];
  assign w_f_qual = (RD_f[6:0] == OP_BRANCH) || (RD_f[6:0] == OP_JAL);
  assign w_f_hit  = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

  assign predict_taken_f = w_f_qual && w_f_hit &&
                           (r_uncond[w_f_idx] || r_ctr[w_f_idx][1]);
  assign branch_target_f = predict_taken_f ? r_target[w_f_idx] : PC_f;

  // ---------------- update ----------------
  logic [IDX_BITS-1:0] w_u_idx;
  logic [TAG_W-1:0]    w_u_tag;
  logic                w_u_hit;
  logic                w_wr_en;
  logic                w_alloc;
  logic                w_wr_target;
  logic [1:0]          w_ctr_next;
  logic                w_uncond_next;

  assign w_u_idx = update_pc[IDX_BITS+1:2];
  assign w_u_tag = update_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  always_comb begin
    w_wr_en       = 1'b0;
    w_alloc       = 1'b0;
    w_wr_target   = 1'b0;
    w_ctr_next    = r_ctr[w_u_idx];
    w_uncond_next = r_uncond[w_u_idx];
    if (update_en) begin
      if (w_u_hit) begin
        w_wr_en = 1'b1;
        if (update_uncond) begin
          w_ctr_next    = 2'b11;
          w_wr_target   = 1'b1;
          w_uncond_next = 1'b1;
        end else begin
          if (update_taken)
            w_ctr_next = (r_ctr[w_u_idx] == 2'b11) ? 2'b11 : r_ctr[w_u_idx] + 2'd1;
          else
            w_ctr_next = (r_ctr[w_u_idx] == 2'b00) ? 2'b00 : r_ctr[w_u_idx] - 2'd1;
          w_wr_target   = update_taken;
          w_uncond_next = 1'b0;
        end
      end else if (update_taken) begin
        // Miss on a taken branch evicts whatever lived in this row.
        w_wr_en       = 1'b1;
        w_alloc       = 1'b1;
        w_wr_target   = 1'b1;
        w_ctr_next    = update_uncond ? 2'b11 : 2'b10;
        w_uncond_next = update_uncond;
      end
    end
  end

  // Valid bits and counters carry reset state; rst overrides any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ROWS; i++) r_ctr[i] <= 2'b01;
    end else if (w_wr_en) begin
      r_ctr[w_u_idx] <= w_ctr_next;
      if (w_alloc) r_valid[w_u_idx] <= 1'b1;
    end
  end

  // Payload fields are don't-care while the row is invalid, so they skip reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_uncond[w_u_idx] <= w_uncond_next;
      if (w_alloc)     r_tag[w_u_idx]    <= w_u_tag;
      if (w_wr_target) r_target[w_u_idx] <= update_target;
    end
  end

  // ---------------- performance counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_lookups     <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_f_qual && (r_perf_lookups != '1))
        r_perf_lookups <= r_perf_lookups + 1'b1;
      if (update_en && mispredict && (r_perf_mispredicts != '1))
        r_perf_mispredicts <= r_perf_mispredicts + 1'b1;
    end
  end

  assign perf_lookups     = r_perf_lookups;
  assign perf_mispredicts = r_perf_mispredicts;

  logic w_unused_bits;
  assign w_unused_bits = ^{RD_f[DATA_WIDTH-1:7], PC_f[1:0], update_pc[1:0]};

endmodule

// File: doc/twobit_btb_predictor.md
# twobit_btb_predictor

Parametrised fetch-stage branch predictor for the pipelined core. It pairs a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. The lookup is combinational on the fetch PC and instruction word. Resolved branches update the table one cycle later from the execute stage. Synchronous reset clears the table, and two saturating performance counters track lookups and mispredictions.

## Interface
Parameters:
- DATA_WIDTH, 32, PC and instruction width.
- BTB_ROWS, 16, BTB entry count; power of two, ≥2. IDX_BITS = $clog2(BTB_ROWS).
- STAT_WIDTH, 16, width of each performance counter.

Ports:
- clk  input  1  the only clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- RD_f  input  DATA_WIDTH  instruction word in fetch.
- PC_f  input  DATA_WIDTH  fetch PC.
- update_en  input  1  a conditional branch or JAL resolved in execute this cycle.
- update_pc  input  DATA_WIDTH  PC of the resolved instruction.
- update_uncond  input  1  the resolved instruction is JAL.
- update_taken  input  1  actual direction.
- update_target  input  DATA_WIDTH  actual target.
- mispredict  input  1  execute flagged a misprediction (valid only with update_en).
- predict_taken_f  output  1  predicted taken.
- branch_target_f  output  DATA_WIDTH  predicted next PC when taken, else PC_f.
- perf_lookups  output  STAT_WIDTH  count of qualifying lookups.
- perf_mispredicts  output  STAT_WIDTH  count of mispredictions.

## Operation
- Fields: index = PC[IDX_BITS+1:2]; tag = PC[DATA_WIDTH-1:IDX_BITS+2].
- Each entry holds: valid, tag, target (DATA_WIDTH), ctr[1:0], uncond.
- Counter encoding: 00 SN, 01 WN, 10 WT, 11 ST. Taken is predicted when ctr[1]=1.
- Lookup is combinational:
  - Qualifying instruction: RD_f[6:0] is 1100011 or 1101111.
  - Hit: the entry is valid and its tag equals the fetch tag.
  - predict_taken_f = qualifying & hit & (uncond | ctr[1]).
  - branch_target_f = entry.target when predict_taken_f, otherwise PC_f.
- Update when update_en=1, on the entry selected by update_pc:
  - Hit, conditional:
    - ctr increments on taken, saturating at 11.
    - ctr decrements on not-taken, saturating at 00.
    - target ← update_target when taken.
    - uncond ← update_uncond.
  - Hit, JAL: ctr ← 11, target ← update_target, uncond ← 1.
  - Miss and taken: allocate (replacing any previous occupant).
    - valid ← 1, tag ← update tag, target ← update_target, uncond ← update_uncond.
    - ctr ← 11 if JAL, else 10 (WT).
  - Miss and not taken: no write.
- update_en=0: table unchanged, whatever the other update inputs are.
- Performance counters:
  - perf_lookups +1 on every cycle with a qualifying RD_f.
  - perf_mispredicts +1 on every cycle with update_en & mispredict.
  - Both saturate at all-ones and never wrap.
- Reset: the cycle rst is sampled high sets every valid ← 0, every ctr ← 01, and both performance counters ← 0. Target, tag and uncond may keep stale values.

## Timing
- Lookup: zero latency; outputs settle combinationally from PC_f, RD_f and the current table.
- Update: the write becomes visible to lookups in the cycle after update_en.
- Lookup and update on the same index in the same cycle: the lookup sees pre-update contents. There is no bypass.
- rst and update_en together: rst wins and the update is dropped. Reset mid-stream simply discards in-flight updates.
- Outputs after reset: predict_taken_f=0, branch_target_f=PC_f, perf_lookups=0, perf_mispredicts=0.
- No stalls or handshakes. At most one update per cycle.

## Test plan
All scenarios use defaults (16 rows, index PC[5:2]).
- **Reset:** assert rst for 1 cycle, then look up PC_f=0x100 with RD_f=0x00000063 → predict_taken_f=0, branch_target_f=0x100, both perf counters 0.
- **Allocate then saturate:**
  - update_pc=0x100, taken, target=0x80 → next-cycle lookup of 0x100 gives taken, target 0x80 (ctr=10).
  - Two not-taken updates → predicts not taken (ctr=00).
  - A third not-taken update keeps ctr=00.
  - Two taken updates → predicts taken again.
- **Hysteresis:** from ST, one not-taken update still predicts taken. A second not-taken update gives not taken.
- **JAL and alias:**
  - JAL at 0x200 to target 0x400 → always predicted taken, even after a not-taken-encoded conditional update would apply.
  - Lookup of 0x240 (same index as 0x200, different tag) → miss, branch_target_f=0x240.
  - A non-branch RD_f (0x00000013) at 0x200 → predict_taken_f=0.
- **Same-cycle collision and reset priority:**
  - Update 0x300 taken while looking up 0x300 → that cycle predicts not taken; the next cycle predicts taken.
  - rst together with update_en → the entry stays invalid.
- **Perf saturation:** with STAT_WIDTH=4, drive 20 qualifying lookups with mispredict every cycle → both counters hold 0xF.
